// File: rtl/array_pkg.sv
// Shared definitions for the sequenced array controller: opcodes, FSM states
// and the cycle-counter width.
package array_pkg;

  localparam logic [1:0] OP_MAC  = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACTIVE,
    ST_RECOVER
  } state_t;

endpackage

// File: rtl/bank_onehot_dec.sv
// Bank-index to one-hot enable decoder; bcast forces all banks on, and an
// index beyond NUM_BANKS decodes to all zeros.
module bank_onehot_dec
  import array_pkg::*;
#(
  parameter int NUM_BANKS = 16,
  parameter int BANK_W    = $clog2(NUM_BANKS)
) (
  input  logic [BANK_W-1:0]    idx,
  input  logic                 en,
  input  logic                 bcast,
  output logic [NUM_BANKS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      onehot[i] = en & (bcast | (idx == BANK_W'(i)));
    end
  end

endmodule

// File: rtl/array_seq_ctrl.sv
// Sequenced CIM array controller: one command at a time through
// SETUP / ACTIVE / RECOVER windows. Define ARRAY_SEQ_BCAST_EN for MAC broadcast.
module array_seq_ctrl
  import array_pkg::*;
#(
  parameter int NUM_BANKS  = 16,
  parameter int BANK_W     = $clog2(NUM_BANKS),
  parameter int WORD_W     = 8,
  parameter int MAC_CYCLES = 4,
  parameter int RD_CYCLES  = 1,
  parameter int WR_CYCLES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [BANK_W-1:0]    cmd_bank,
  input  logic [WORD_W-1:0]    cmd_word,
`ifdef ARRAY_SEQ_BCAST_EN
  input  logic                 cmd_bcast,
`endif
  output logic                 mac_en,
  output logic                 read_bar,
  output logic                 w_en,
  output logic [NUM_BANKS-1:0] bank_en,
  output logic [WORD_W-1:0]    word_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [BANK_W:0] NB = (BANK_W+1)'(NUM_BANKS);

  function automatic logic [CNT_W-1:0] win_len(input logic [1:0] op);
    case (op)
      OP_RD:   win_len = CNT_W'(RD_CYCLES);
      OP_WR:   win_len = CNT_W'(WR_CYCLES);
      default: win_len = CNT_W'(MAC_CYCLES);
    endcase
  endfunction

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;

  logic [1:0]         r_op;
  logic [BANK_W-1:0]  r_bank, w_bank_nxt;
  logic [WORD_W-1:0]  r_word, w_word_nxt;
  logic               r_bcast, w_bcast_nxt, w_bcast_in;

  logic               w_accept, w_bank_ok, w_cmd_ok, w_reject;

  logic               r_ready, r_mac, r_rdb, r_wen, r_busy, r_done, r_err;
  logic [NUM_BANKS-1:0] r_bank_en, w_bank_en_nxt;
  logic [WORD_W-1:0]  r_word_out, w_word_out_nxt;
  logic               w_ready_nxt, w_mac_nxt, w_rdb_nxt, w_wen_nxt;
  logic               w_busy_nxt, w_done_nxt, w_err_nxt;

`ifdef ARRAY_SEQ_BCAST_EN
  assign w_bcast_in = cmd_bcast;
`else
  assign w_bcast_in = 1'b0;
`endif

  // r_ready is only ever high in IDLE, so it doubles as the accept qualifier
  assign w_accept  = cmd_valid & r_ready;
  assign w_bank_ok = ({1'b0, cmd_bank} < NB);
  assign w_cmd_ok  = (cmd_op != OP_RSVD) &&
                     (w_bcast_in ? (cmd_op == OP_MAC) : w_bank_ok);
  assign w_reject  = w_accept & ~w_cmd_ok;

  assign w_bank_nxt  = w_accept ? cmd_bank   : r_bank;
  assign w_word_nxt  = w_accept ? cmd_word   : r_word;
  assign w_bcast_nxt = w_accept ? w_bcast_in : r_bcast;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op    <= cmd_op;
      r_bank  <= cmd_bank;
      r_word  <= cmd_word;
      r_bcast <= w_bcast_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_cmd_ok) w_state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        w_state_nxt = ST_ACTIVE;
        w_cnt_nxt   = win_len(r_op);
      end
      ST_ACTIVE: begin
        if (r_cnt <= CNT_W'(1)) w_state_nxt = ST_RECOVER;
        else                    w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      ST_RECOVER: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so every strobe comes off a flop
  always_comb begin
    w_busy_nxt     = (w_state_nxt != ST_IDLE);
    w_ready_nxt    = (w_state_nxt == ST_IDLE);
    w_done_nxt     = (w_state_nxt == ST_RECOVER);
    w_err_nxt      = w_reject;
    w_mac_nxt      = (w_state_nxt == ST_ACTIVE) && (r_op == OP_MAC);
    w_rdb_nxt      = !((w_state_nxt == ST_ACTIVE) && (r_op == OP_RD));
    w_wen_nxt      = (w_state_nxt == ST_ACTIVE) && (r_op == OP_WR);
    w_word_out_nxt = w_busy_nxt ? w_word_nxt : '0;
  end

  bank_onehot_dec #(
    .NUM_BANKS (NUM_BANKS),
    .BANK_W    (BANK_W)
  ) u_dec (
    .idx    (w_bank_nxt),
    .en     (w_busy_nxt),
    .bcast  (w_bcast_nxt),
    .onehot (w_bank_en_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready    <= 1'b0;
      r_mac      <= 1'b0;
      r_rdb      <= 1'b1;
      r_wen      <= 1'b0;
      r_bank_en  <= '0;
      r_word_out <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_ready    <= w_ready_nxt;
      r_mac      <= w_mac_nxt;
      r_rdb      <= w_rdb_nxt;
      r_wen      <= w_wen_nxt;
      r_bank_en  <= w_bank_en_nxt;
      r_word_out <= w_word_out_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign cmd_ready = r_ready;
  assign mac_en    = r_mac;
  assign read_bar  = r_rdb;
  assign w_en      = r_wen;
  assign bank_en   = r_bank_en;
  assign word_out  = r_word_out;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule
